serial_addsub_ctrl: RTL

Bit-serial add/subtract sequencer that time-shares one full-adder/full-subtractor bit cell across all bits of a WIDTH-bit operation. It captures operands through a valid/ready handshake and walks LSB-first through the bits, one bit per cycle, with a carry/borrow flip-flop. It returns the result, carry/borrow-out and an optional signed-overflow flag through a second valid/ready handshake. It is the area-minimal arithmetic path for the adder library, sitting between an operand producer and a result consumer.

---
 rtl/serial_addsub_ctrl.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl
//
// Bit-serial add/subtract sequencer. A single full-adder/full-subtractor bit
// cell is reused for every bit of a WIDTH-bit operation. It walks from the LSB
// upward, one bit per clock, and keeps the carry/borrow in a flip-flop between
// bits. Operands enter through a valid/ready handshake. The result leaves
// through a second valid/ready handshake.
//
// Optional feature macro: SERIAL_ADDSUB_OVF_EN
//   defined   -> the ovf port and the signed-overflow logic exist
//   undefined -> no ovf port, no overflow logic
//
// Parameters:
//   WIDTH      operand/result width, 2..64
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous, active-low reset
//   in_valid   operand request
//   in_ready   block is idle and can accept an operation
//   a, b       augend/minuend and addend/subtrahend
//   sub        0: a+b+cin   1: a-b-cin
//   cin        carry-in (add) or borrow-in (sub)
//   out_valid  result available
//   out_ready  consumer accepts the result
//   result     sum or difference, modulo 2^WIDTH
//   cout       carry-out (add) or borrow-out (sub)
//   ovf        signed two's-complement overflow (SERIAL_ADDSUB_OVF_EN only)
// -----------------------------------------------------------------------------
module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef SERIAL_ADDSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic             r_c;
  logic             r_sub;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  // Only WIDTH-1 bits are held here. The final bit goes straight into result.
  logic [WIDTH-2:0] r_res_sh;
  logic [WIDTH-1:0] r_result;
  logic             r_cout;

  logic             w_x;
  logic             w_y;
  logic             w_s;
  logic             w_c_next;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_res_full;

  // Shared bit cell. The sum bit is the same for add and subtract. Only the
  // carry/borrow equation differs.
  assign w_x        = r_a_sh[0];
  assign w_y        = r_b_sh[0];
  assign w_s        = w_x ^ w_y ^ r_c;
  assign w_c_next   = r_sub ? ((~w_x & w_y) | (r_c & ~(w_x ^ w_y)))
                            : (( w_x & w_y) | (r_c &  (w_x ^ w_y)));
  assign w_last     = (r_cnt == LAST);
  assign w_res_full = {w_s, r_res_sh};

  // in_ready is qualified with rst_n. This keeps it low for the whole reset
  // window, including the first reset cycle when the state has not yet
  // returned to IDLE. It rises in the first cycle after release.
  assign in_ready  = (r_state == IDLE) && rst_n;
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid && in_ready;

  assign result = r_result;
  assign cout   = r_cout;

`ifdef SERIAL_ADDSUB_OVF_EN
  logic r_ovf;
  logic w_ovf_next;
  // At the last bit, x and y are the captured operand MSBs and s is the
  // result MSB, so overflow needs no extra storage.
  assign w_ovf_next = r_sub ? ((w_x != w_y) && (w_s != w_x))
                            : ((w_x == w_y) && (w_s != w_x));
  assign ovf = r_ovf;
`endif

  // Control FSM and visible outputs.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_c      <= 1'b0;
      r_result <= '0;
      r_cout   <= 1'b0;
`ifdef SERIAL_ADDSUB_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state <= RUN;
            r_cnt   <= '0;
            r_c     <= cin;
          end
        end
        RUN: begin
          r_c <= w_c_next;
          if (w_last) begin
            // Leave the counter at 0 instead of letting it wrap past WIDTH-1.
            r_cnt    <= '0;
            r_result <= w_res_full;
            r_cout   <= w_c_next;
`ifdef SERIAL_ADDSUB_OVF_EN
            r_ovf    <= w_ovf_next;
`endif
            r_state  <= DONE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Operand and partial-result shift registers.
  // NOTE: these datapath registers are deliberately not reset. Each is fully
  // reloaded on accept, or refilled before it is read, so reset adds nothing
  // but fanout.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a_sh <= a;
      r_b_sh <= b;
      r_sub  <= sub;
    end else if (r_state == RUN) begin
      r_a_sh   <= r_a_sh >> 1;
      r_b_sh   <= r_b_sh >> 1;
      r_res_sh <= w_res_full[WIDTH-1:1];
    end
  end

endmodule
